writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage. Accepts completed results from execute through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each result onto the register file's single GPR write port, plus its PC and CPSR write ports.
- Steers any write targeting r15 onto the PC port, because the register file increments PC whenever pc_we is low.
- Publishes a pending-write mask so decode can stall on RAW hazards.

Parameters:
- WORD_SIZE, 32, datapath width.
- NUM_REGS, 16, architectural GPR count, r15 = PC.
- ADDR_WIDTH, 4, register index width, log2(NUM_REGS).
- FIFO_DEPTH, 2, result entries buffered; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset: asserted when 0.
- in_valid  in  1  execute result valid.
- in_ready  out  1  unit can accept a result.
- in_rd_en  in  1  primary destination write requested.
- in_rd_addr  in  ADDR_WIDTH  primary destination index.
- in_rd_data  in  WORD_SIZE  primary destination value.
- in_rn_en  in  1  base-register writeback requested (LDR/STR with writeback).
- in_rn_addr  in  ADDR_WIDTH  base index.
- in_rn_data  in  WORD_SIZE  updated base value.
- in_cpsr_en  in  1  flags update requested.
- in_cpsr_data  in  WORD_SIZE  new CPSR.
- rd_we  out  1  to register file.
- write_rd  out  ADDR_WIDTH  to register file.
- rd_in  out  WORD_SIZE  to register file.
- pc_we  out  1  to register file.
- pc_in  out  WORD_SIZE  to register file.
- cpsr_we  out  1  to register file.
- cpsr_in  out  WORD_SIZE  to register file.
- pending_mask  out  NUM_REGS  bit i set while any queued or in-progress entry will write GPR i.
- busy  out  1  FIFO non-empty.

Behaviour:
Reset
- While reset = 0: FIFO empty, FSM in IDLE, in_ready = 0.
- All *_we, write_rd, rd_in, pc_in, cpsr_in and pending_mask are 0; busy = 0.
- in_ready rises in the first cycle after reset deasserts.
- Reset mid-operation discards all queued entries and any second write in flight.

Handshake
- Push occurs on an edge where in_valid && in_ready.
- in_ready = !full. There is no same-cycle pass-through; a full FIFO refuses input even when a pop happens in the same cycle.
- Pop and push in the same cycle are legal when not full.
- An entry with no enables set is accepted and retired in one cycle with no writes.

Latency
- An entry pushed at edge N can be at the head in cycle N+1. Outputs are combinational from the head entry plus FSM state, so its first writes land in the register file at edge N+2.

FSM
- IDLE: FIFO empty, all we outputs 0.
- WRITE1: head present. Drive the primary GPR write, the PC write and the CPSR write together. If the head needs a second GPR write, go to WRITE2 and do not pop; otherwise pop and stay in WRITE1, or go to IDLE if the FIFO becomes empty.
- WRITE2: drive rd_we with rn_addr and rn_data, pop, then go to WRITE1 or IDLE.

Steering rules
- rd_addr == 15 with rd_en: use the PC port (pc_we = 1, pc_in = rd_data), never rd_we.
- rn_addr == 15 with rn_en: use the PC port in WRITE1.
- Both rd and rn target r15: rd wins, rn is dropped.
- rd_addr == rn_addr, both enabled: rd wins, single cycle, no WRITE2.
- Exactly one non-PC GPR write: issued in WRITE1. Only rn enabled: rn is issued in WRITE1.
- The second write happens only when both rd and rn are enabled, neither is r15, and the addresses differ.
- cpsr_we is asserted in WRITE1 only.

Scoreboard
- pending_mask is recomputed from valid FIFO entries.
- A bit clears on the edge its last pending write retires.
- r15 bits are never set.

Pointers
- FIFO pointers are ADDR-free modulo FIFO_DEPTH counters with wrap-around.
- Occupancy count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package arm_wb_pkg:
  - wb_entry_t struct holding all in_* fields.
  - PC_INDEX = 15.
  - wb_state_t enum {IDLE, WRITE1, WRITE2}.
- One sub-module, wb_fifo: generic synchronous FIFO of wb_entry_t with full/empty/count and asynchronous active-low reset.
- The FSM, steering and scoreboard stay in writeback_unit.

Test Plan:
1. Reset held low for 3 cycles with in_valid = 1 → in_ready = 0, all we outputs = 0, pending_mask = 0; one cycle after release, in_ready = 1.
2. Push {rd_en, r3, 0x11} at edge N → at edge N+2 rd_we = 1, write_rd = 3, rd_in = 0x11; pending_mask[3] is set for cycles N+1 to N+2 and clears after the edge.
3. Push {rd r2 = 0xAA, rn r5 = 0x1004, cpsr_en = 0x80000000} → WRITE1 writes r2 and the CPSR, WRITE2 writes r5 = 0x1004; pending_mask[2] clears after WRITE1, pending_mask[5] clears after WRITE2.
4. Push {rd_en, r15, 0x200} → pc_we = 1, pc_in = 0x200, rd_we = 0. Then push rd and rn both r15 → only pc_in = rd_data is written.
5. Back-to-back pushes of three two-write entries with in_valid held → in_ready drops when the FIFO is full; no entry is lost or reordered; GPR writes appear in order rd0, rn0, rd1, rn1, rd2, rn2.
6. Assert reset in WRITE2 with 2 entries queued → the rn write is aborted, the FIFO empties, and after release pending_mask = 0 and busy = 0.

Source files
------------

// File: rtl/arm_wb_pkg.sv
// +--------------------------------------------------------------------+
// | arm_wb_pkg: shared types and steering helpers for writeback_unit    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package arm_wb_pkg;

  localparam int WB_WORD_SIZE  = 32;
  localparam int WB_ADDR_WIDTH = 4;
  localparam int WB_NUM_REGS   = 16;

  localparam logic [WB_ADDR_WIDTH-1:0] PC_INDEX = 4'd15;

  typedef struct packed {
    logic                     rd_en;
    logic [WB_ADDR_WIDTH-1:0] rd_addr;
    logic [WB_WORD_SIZE-1:0]  rd_data;
    logic                     rn_en;
    logic [WB_ADDR_WIDTH-1:0] rn_addr;
    logic [WB_WORD_SIZE-1:0]  rn_data;
    logic                     cpsr_en;
    logic [WB_WORD_SIZE-1:0]  cpsr_data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE1 = 2'd1,
    WRITE2 = 2'd2
  } wb_state_t;

  function automatic logic rd_to_gpr(wb_entry_t e);
    return e.rd_en && (e.rd_addr != PC_INDEX);
  endfunction

  function automatic logic rd_to_pc(wb_entry_t e);
    return e.rd_en && (e.rd_addr == PC_INDEX);
  endfunction

  // rn loses to rd whenever both name the same register (including r15)
  function automatic logic rn_to_gpr(wb_entry_t e);
    return e.rn_en && (e.rn_addr != PC_INDEX) && !(e.rd_en && (e.rd_addr == e.rn_addr));
  endfunction

  function automatic logic rn_to_pc(wb_entry_t e);
    return e.rn_en && (e.rn_addr == PC_INDEX) && !rd_to_pc(e);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +--------------------------------------------------------------------+
// | wb_fifo: synchronous FIFO of wb_entry_t exposing every slot          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import arm_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             wr_data,
  input  logic                  pop,
  output wb_entry_t             rd_data,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic      [DEPTH-1:0] valid,
  output logic      [PTR_W-1:0] head_idx,
  output logic                  full,
  output logic                  empty,
  output logic      [PTR_W:0]   count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_data  = mem[rd_ptr];
  assign entries  = mem;
  assign head_idx = rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // a slot is live when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset   = PTR_W'(i) - rd_ptr;
    assign valid[i] = ({1'b0, offset} < count);
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// +--------------------------------------------------------------------+
// | writeback_unit: buffers execute results, serialises register writes |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module writeback_unit
  import arm_wb_pkg::*;
#(
  parameter int WORD_SIZE  = WB_WORD_SIZE,
  parameter int NUM_REGS   = WB_NUM_REGS,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rd_en,
  input  logic [ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [WORD_SIZE-1:0]  in_rd_data,
  input  logic                  in_rn_en,
  input  logic [ADDR_WIDTH-1:0] in_rn_addr,
  input  logic [WORD_SIZE-1:0]  in_rn_data,
  input  logic                  in_cpsr_en,
  input  logic [WORD_SIZE-1:0]  in_cpsr_data,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  cpsr_we,
  output logic [WORD_SIZE-1:0]  cpsr_in,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  wb_state_t state;
  wb_state_t state_nxt;
  logic      ready_q;
  logic      push;
  logic      pop;
  logic      more;
  wb_entry_t in_entry;
  wb_entry_t head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic      [FIFO_DEPTH-1:0] valid;
  logic      [PTR_W-1:0]      head_idx;
  logic      full;
  logic      empty;
  logic      [PTR_W:0]        count;

  assign in_entry = '{rd_en: in_rd_en, rd_addr: in_rd_addr, rd_data: in_rd_data,
                      rn_en: in_rn_en, rn_addr: in_rn_addr, rn_data: in_rn_data,
                      cpsr_en: in_cpsr_en, cpsr_data: in_cpsr_data};

  // ready_q keeps in_ready low throughout reset and rises on the first edge after it
  assign in_ready = ready_q && !full;
  assign push     = in_valid && in_ready;
  assign busy     = !empty;
  assign more     = (count > (PTR_W+1)'(1)) || push;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_data  (in_entry),
    .pop      (pop),
    .rd_data  (head),
    .entries  (entries),
    .valid    (valid),
    .head_idx (head_idx),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rd_we     = 1'b0;
    write_rd  = '0;
    rd_in     = '0;
    pc_we     = 1'b0;
    pc_in     = '0;
    cpsr_we   = 1'b0;
    cpsr_in   = '0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = WRITE1;
      end
      WRITE1: begin
        if (empty) begin
          state_nxt = IDLE;
        end else begin
          if (rd_to_gpr(head)) begin
            rd_we    = 1'b1;
            write_rd = head.rd_addr;
            rd_in    = head.rd_data;
          end else if (rn_to_gpr(head)) begin
            rd_we    = 1'b1;
            write_rd = head.rn_addr;
            rd_in    = head.rn_data;
          end
          if (rd_to_pc(head)) begin
            pc_we = 1'b1;
            pc_in = head.rd_data;
          end else if (rn_to_pc(head)) begin
            pc_we = 1'b1;
            pc_in = head.rn_data;
          end
          if (head.cpsr_en) begin
            cpsr_we = 1'b1;
            cpsr_in = head.cpsr_data;
          end
          if (rd_to_gpr(head) && rn_to_gpr(head)) begin
            state_nxt = WRITE2;
          end else begin
            pop       = 1'b1;
            state_nxt = more ? WRITE1 : IDLE;
          end
        end
      end
      WRITE2: begin
        rd_we     = 1'b1;
        write_rd  = head.rn_addr;
        rd_in     = head.rn_data;
        pop       = 1'b1;
        state_nxt = more ? WRITE1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // the head's rd has already retired once the FSM is in WRITE2
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid[i]) begin
        if (rd_to_gpr(entries[i]) && !((state == WRITE2) && (PTR_W'(i) == head_idx)))
          pending_mask[entries[i].rd_addr] = 1'b1;
        if (rn_to_gpr(entries[i]))
          pending_mask[entries[i].rn_addr] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// +--------------------------------------------------------------------+
// | tb_writeback_unit: scoreboard bench for writeback_unit              |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_writeback_unit;

  typedef struct packed {
    logic        rd_en;
    logic [3:0]  rd_a;
    logic [31:0] rd_d;
    logic        rn_en;
    logic [3:0]  rn_a;
    logic [31:0] rn_d;
    logic        c_en;
    logic [31:0] c_d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_rd_en = 1'b0;
  logic [3:0]  in_rd_addr = '0;
  logic [31:0] in_rd_data = '0;
  logic        in_rn_en = 1'b0;
  logic [3:0]  in_rn_addr = '0;
  logic [31:0] in_rn_data = '0;
  logic        in_cpsr_en = 1'b0;
  logic [31:0] in_cpsr_data = '0;
  logic        rd_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in;
  logic        pc_we;
  logic [31:0] pc_in;
  logic        cpsr_we;
  logic [31:0] cpsr_in;
  logic [15:0] pending_mask;
  logic        busy;

  writeback_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd_en     (in_rd_en),
    .in_rd_addr   (in_rd_addr),
    .in_rd_data   (in_rd_data),
    .in_rn_en     (in_rn_en),
    .in_rn_addr   (in_rn_addr),
    .in_rn_data   (in_rn_data),
    .in_cpsr_en   (in_cpsr_en),
    .in_cpsr_data (in_cpsr_data),
    .rd_we        (rd_we),
    .write_rd     (write_rd),
    .rd_in        (rd_in),
    .pc_we        (pc_we),
    .pc_in        (pc_in),
    .cpsr_we      (cpsr_we),
    .cpsr_in      (cpsr_in),
    .pending_mask (pending_mask),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit stall_seen = 1'b0;

  logic [35:0] gpr_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] cpsr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic rde, input int rda, input logic [31:0] rdd,
                              input logic rne, input int rna, input logic [31:0] rnd,
                              input logic ce, input logic [31:0] cd);
    ent_t e;
    e.rd_en = rde; e.rd_a = 4'(rda); e.rd_d = rdd;
    e.rn_en = rne; e.rn_a = 4'(rna); e.rn_d = rnd;
    e.c_en  = ce;  e.c_d  = cd;
    return e;
  endfunction

  // reference model of the register-file writes an accepted entry must produce
  task automatic model_push(input ent_t e);
    bit rd_pc;
    rd_pc = e.rd_en && (e.rd_a == 4'd15);
    if (rd_pc)         pc_q.push_back(e.rd_d);
    else if (e.rd_en)  gpr_q.push_back({e.rd_a, e.rd_d});
    if (e.rn_en) begin
      if (e.rn_a == 4'd15) begin
        if (!rd_pc) pc_q.push_back(e.rn_d);
      end else if (!(e.rd_en && e.rd_a == e.rn_a)) begin
        gpr_q.push_back({e.rn_a, e.rn_d});
      end
    end
    if (e.c_en) cpsr_q.push_back(e.c_d);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (rd_we) begin
        if (gpr_q.size() == 0) check_eq("gpr_unexpected", 32'(write_rd), 32'hFFFF_FFFF);
        else begin
          logic [35:0] x;
          x = gpr_q.pop_front();
          check_eq("gpr_addr", 32'(write_rd), 32'(x[35:32]));
          check_eq("gpr_data", rd_in, x[31:0]);
        end
      end
      if (pc_we) begin
        if (pc_q.size() == 0) check_eq("pc_unexpected", pc_in, 32'hFFFF_FFFF);
        else check_eq("pc_data", pc_in, pc_q.pop_front());
      end
      if (cpsr_we) begin
        if (cpsr_q.size() == 0) check_eq("cpsr_unexpected", cpsr_in, 32'hFFFF_FFFF);
        else check_eq("cpsr_data", cpsr_in, cpsr_q.pop_front());
      end
    end
  end

  // leaves in_valid high so consecutive calls form a back-to-back burst
  task automatic push_entry(input ent_t e);
    bit accepted;
    in_valid = 1'b1;
    in_rd_en = e.rd_en; in_rd_addr = e.rd_a; in_rd_data = e.rd_d;
    in_rn_en = e.rn_en; in_rn_addr = e.rn_a; in_rn_data = e.rn_d;
    in_cpsr_en = e.c_en; in_cpsr_data = e.c_d;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        model_push(e);
      end else begin
        stall_seen = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_rd_en = 1'b0; in_rn_en = 1'b0; in_cpsr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!busy && (state_is_idle())) done = 1'b1;
    end
    if (!done) check_eq(tag, 32'd0, 32'd1);
  endtask

  function automatic bit state_is_idle();
    return !rd_we && !pc_we && !cpsr_we;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // reset held with in_valid asserted
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
      check_eq("rst_mask", 32'(pending_mask), 32'd0);
    end
    check_eq("rst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // single GPR write: latency and mask lifetime
    push_entry(mk(1, 3, 32'h11, 0, 0, 0, 0, 0));
    idle_in();
    @(negedge clk);
    check_eq("t2_mask_n1", 32'(pending_mask), 32'h0008);
    check_eq("t2_we_early", 32'(rd_we), 32'd0);
    @(negedge clk);
    check_eq("t2_rd_we", 32'(rd_we), 32'd1);
    check_eq("t2_write_rd", 32'(write_rd), 32'd3);
    check_eq("t2_rd_in", rd_in, 32'h11);
    check_eq("t2_mask_n2", 32'(pending_mask), 32'h0008);
    @(negedge clk);
    check_eq("t2_mask_clear", 32'(pending_mask), 32'd0);
    check_eq("t2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // rd + rn + cpsr entry: two GPR cycles
    push_entry(mk(1, 2, 32'hAA, 1, 5, 32'h1004, 1, 32'h8000_0000));
    idle_in();
    @(negedge clk);
    check_eq("t3_mask0", 32'(pending_mask), 32'h0024);
    @(negedge clk);
    check_eq("t3_w1_addr", 32'(write_rd), 32'd2);
    check_eq("t3_w1_cpsr", 32'(cpsr_we), 32'd1);
    check_eq("t3_w1_mask", 32'(pending_mask), 32'h0024);
    @(negedge clk);
    check_eq("t3_w2_addr", 32'(write_rd), 32'd5);
    check_eq("t3_w2_data", rd_in, 32'h1004);
    check_eq("t3_w2_cpsr", 32'(cpsr_we), 32'd0);
    check_eq("t3_w2_mask", 32'(pending_mask), 32'h0020);
    @(negedge clk);
    check_eq("t3_mask_end", 32'(pending_mask), 32'd0);
    @(posedge clk); #1;

    // r15 steering
    push_entry(mk(1, 15, 32'h200, 0, 0, 0, 0, 0));
    idle_in();
    @(negedge clk);
    check_eq("t4_mask_r15", 32'(pending_mask), 32'd0);
    @(negedge clk);
    check_eq("t4_pc_we", 32'(pc_we), 32'd1);
    check_eq("t4_pc_in", pc_in, 32'h200);
    check_eq("t4_rd_we", 32'(rd_we), 32'd0);
    @(posedge clk); #1;
    push_entry(mk(1, 15, 32'h300, 1, 15, 32'h400, 0, 0));
    idle_in();
    @(negedge clk);
    @(negedge clk);
    check_eq("t4b_pc_in", pc_in, 32'h300);
    check_eq("t4b_rd_we", 32'(rd_we), 32'd0);
    @(negedge clk);
    check_eq("t4b_no_second", 32'(pc_we), 32'd0);
    @(posedge clk); #1;

    // corner cases: rn only, rd==rn, rd r15 with GPR rn, rn r15 with GPR rd, empty entry
    push_entry(mk(0, 0, 0, 1, 9, 32'h99, 0, 0));
    push_entry(mk(1, 4, 32'h44, 1, 4, 32'h55, 0, 0));
    push_entry(mk(1, 15, 32'h500, 1, 6, 32'h66, 1, 32'h1));
    push_entry(mk(1, 7, 32'h77, 1, 15, 32'h600, 0, 0));
    push_entry(mk(0, 0, 0, 0, 0, 0, 0, 0));
    idle_in();
    wait_idle("t_corner_drain");
    check_eq("t_corner_gpr_left", 32'(gpr_q.size()), 32'd0);
    check_eq("t_corner_pc_left", 32'(pc_q.size()), 32'd0);

    // back-to-back two-write burst must stall and keep order
    @(posedge clk); #1;
    stall_seen = 1'b0;
    for (int k = 0; k < 3; k++)
      push_entry(mk(1, 1 + 2*k, 32'hD0 + 32'(k), 1, 2 + 2*k, 32'hE0 + 32'(k), 0, 0));
    idle_in();
    check_eq("t5_stall_seen", 32'(stall_seen), 32'd1);
    wait_idle("t5_drain");
    check_eq("t5_gpr_left", 32'(gpr_q.size()), 32'd0);

    // reset during WRITE2 with a second entry queued
    @(posedge clk); #1;
    push_entry(mk(1, 7, 32'hA7, 1, 8, 32'hA8, 0, 0));
    push_entry(mk(1, 9, 32'hA9, 1, 10, 32'hAA, 0, 0));
    idle_in();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (rd_we && write_rd == 4'd8) found = 1'b1;
    end
    check_eq("t6_reach_write2", 32'(found), 32'd1);
    #1 reset = 1'b0;
    gpr_q.delete(); pc_q.delete(); cpsr_q.delete();
    #1;
    check_eq("t6_rst_we", 32'(rd_we), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("t6_mask", 32'(pending_mask), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_ready", 32'(in_ready), 32'd1);
    check_eq("t6_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("end_gpr_q", 32'(gpr_q.size()), 32'd0);
    check_eq("end_pc_q", 32'(pc_q.size()), 32'd0);
    check_eq("end_cpsr_q", 32'(cpsr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
